// File: rtl/testpoint_monitor_if.sv
// Control/result bundle for testpoint_monitor.
// The master side (board control) drives the measurement set-up and start/abort.
// The slave side (the monitor) returns status and the result.
interface testpoint_monitor_if #(
  parameter int SEL_W = 3,
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
);
  logic [SEL_W-1:0] sel;
  logic [1:0]       mode;
  logic [WIN_W-1:0] win_len;
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             tp_level;

  modport master (
    output sel, mode, win_len, start, abort,
    input  busy, done, count, ovf, tp_level
  );

  modport slave (
    input  sel, mode, win_len, start, abort,
    output busy, done, count, ovf, tp_level
  );
endinterface

// File: rtl/testpoint_monitor.sv
// Test-point monitor: synchronises N_CH asynchronous probe signals, selects one,
// and measures it over a programmable window.
// Measurements are rising, falling or both-edge counts, or high-cycle counts.
// The counter saturates, and the ovf flag records that an event was lost.
module testpoint_monitor #(
  parameter int N_CH        = 8,
  parameter int SEL_W       = $clog2(N_CH),
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH-1:0]     tp_in,
  testpoint_monitor_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;
  typedef enum logic [1:0] {M_RISE, M_FALL, M_BOTH, M_HIGH} mode_t;

  logic [N_CH-1:0]  r_sync [SYNC_STAGES];
  state_t           r_state;
  logic [SEL_W-1:0] r_sel_q;
  mode_t            r_mode_q;
  logic             r_prev;
  logic [WIN_W-1:0] r_remaining;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic [N_CH-1:0]  w_s;
  logic [SEL_W-1:0] w_live_sel;
  logic             w_cur;
  logic             w_event;

  // Out-of-range selects fall back to channel 0.
  function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] s);
    if ({1'b0, s} >= (SEL_W+1)'(N_CH)) return '0;
    return s;
  endfunction

  // Synchroniser chain per channel.
  // NOTE: every stage is reset so that tp_level and the prev preload are 0 from reset, not X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '{default: '0};
    end else begin
      r_sync[0] <= tp_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_s          = r_sync[SYNC_STAGES-1];
  assign w_live_sel   = clamp_sel(bus.sel);
  assign w_cur        = w_s[r_sel_q];
  assign bus.tp_level = w_s[w_live_sel];

  // Event detect for the latched mode on the latched channel.
  // NOTE: the default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    w_event = 1'b0;
    case (r_mode_q)
      M_RISE:  w_event = w_cur & ~r_prev;
      M_FALL:  w_event = ~w_cur & r_prev;
      M_BOTH:  w_event = w_cur ^ r_prev;
      M_HIGH:  w_event = w_cur;
      default: w_event = 1'b0;
    endcase
  end

  // Measurement FSM with registered busy/done/count/ovf.
  // NOTE: all state here updates with non-blocking assignments, so every read sees the pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sel_q     <= '0;
      r_mode_q    <= M_RISE;
      r_prev      <= 1'b0;
      r_remaining <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A start together with an abort is ignored.
          if (bus.start && !bus.abort) begin
            r_sel_q  <= w_live_sel;
            r_mode_q <= mode_t'(bus.mode);
            r_count  <= '0;
            r_ovf    <= 1'b0;
            // Preload from the new channel so the window opens without a false edge.
            r_prev   <= w_s[w_live_sel];
            if (bus.win_len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_remaining <= bus.win_len;
              r_state     <= S_COUNT;
              r_busy      <= 1'b1;
            end
          end
        end
        S_COUNT: begin
          if (bus.abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_count <= '0;
            r_ovf   <= 1'b0;
          end else begin
            if (w_event) begin
              if (&r_count) r_ovf   <= 1'b1;
              else          r_count <= r_count + 1'b1;
            end
            r_prev      <= w_cur;
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == WIN_W'(1)) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.count = r_count;
  assign bus.ovf   = r_ovf;

endmodule

// File: doc/testpoint_monitor.md
# testpoint_monitor

Parametrised successor to the passive board test point. It synchronises `N_CH` asynchronous test-point signals, selects one, and measures it over a programmable window of clock cycles: rising, falling or both-edge counts, or high time. It sits beside the trigger-board logic as a debug/bring-up aid. Results are read by the board control interface.

## Interface
Parameters:
- `N_CH`, 8: number of test-point inputs, must be ≥ 2.
- `SEL_W`, `$clog2(N_CH)`: channel-select width.
- `CNT_W`, 16: result counter width.
- `WIN_W`, 16: window-length width.
- `SYNC_STAGES`, 2: synchroniser depth, must be ≥ 2.

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `tp_in`, in, N_CH: asynchronous test-point signals.
- `sel`, in, SEL_W: channel select, sampled at start.
- `mode`, in, 2: 00 rising edges, 01 falling edges, 10 both edges, 11 high cycles; sampled at start.
- `win_len`, in, WIN_W: window length in cycles, sampled at start.
- `start`, in, 1: 1-cycle start request.
- `abort`, in, 1: cancel a measurement.
- `busy`, out, 1: high while in COUNT.
- `done`, out, 1: 1-cycle pulse, result valid.
- `count`, out, CNT_W: measured value.
- `ovf`, out, 1: counter saturated during the last window.
- `tp_level`, out, 1: synchronised level of the channel selected by live `sel`, for static probing.

## Operation
- Each `tp_in` bit passes through a `SYNC_STAGES` flop chain, reset to 0. All logic below uses the synchronised values `s[i]`.
- `sel` ≥ `N_CH` selects channel 0.
- FSM states are IDLE, COUNT and DONE. Reset state is IDLE.
- IDLE:
  - `start`=1 and `abort`=0 → latch `sel_q`, `mode_q`; clear `count` and `ovf`; `prev` ← `s[sel_q]`.
  - If `win_len`=0, go to DONE with `count`=0.
  - Otherwise load `remaining` ← `win_len` and go to COUNT.
  - `start` and `abort` together in IDLE → stay in IDLE with nothing changed.
- COUNT, each cycle:
  - Event is evaluated on `cur`=`s[sel_q]` versus `prev`:
    - rising: `cur & ~prev`
    - falling: `~cur & prev`
    - both: `cur ^ prev`
    - high: `cur`
  - On an event, `count` increments. At all-ones it holds and `ovf` sets sticky.
  - `prev` ← `cur`; `remaining` decrements.
  - When `remaining`=1 this cycle, go to DONE. Exactly `win_len` cycles are sampled.
- COUNT with `abort`=1 → IDLE. That cycle's event is not counted, `count` and `ovf` clear to 0, and `done` is not asserted.
- `start` during COUNT or DONE is ignored.
- DONE: `done`=1 for one cycle, then IDLE. `count` and `ovf` hold until the next accepted start.
- Changes to `sel`, `mode` or `win_len` during COUNT have no effect on the measurement. `tp_level` follows live `sel`.

## Timing
- Reset values: `busy`=0, `done`=0, `count`=0, `ovf`=0, `tp_level`=0; all sync flops, `prev` and `remaining` are 0.
- Start accepted at edge k: `busy`=1 from k+1 through k+`win_len`; `done`=1 in cycle k+`win_len`+1.
- For `win_len`=0: `done`=1 in cycle k+1 and `busy` stays 0.
- Input-to-event latency is `SYNC_STAGES` cycles from `tp_in` change to `s` change. The edge is counted in the cycle `s` changes.
- No false edge at window open: `prev` is preloaded from the newly selected channel.
- Back-to-back: a `start` in the cycle `done`=1 is ignored. The earliest next start is accepted in the following (IDLE) cycle.
- Reset mid-COUNT: all outputs return to their reset values asynchronously and no `done` is produced.

## Test plan
- Reset, then idle for 10 cycles → `busy`=`done`=`count`=`ovf`=0.
- Channel 3 toggled every 4 cycles, `mode`=00, `win_len`=40, start → `done` at start+41 with `count`=5 (±1 by phase); channel 3 held high with `mode`=11 → `count`=40.
- `CNT_W`=4, channel 0 toggles every cycle, `mode`=10, `win_len`=50 → `count`=15, `ovf`=1.
- `win_len`=0 → `done` one cycle after start, `count`=0, `busy` never high.
- `abort` at cycle 10 of a 100-cycle window → `busy` drops, no `done`, `count`=0; a following start is accepted normally.
- `sel` changed mid-window, `start` pulsed during COUNT, and `rst_n` pulsed low mid-COUNT → result unaffected by `sel` and `start`; reset gives all-zero outputs with no `done`.
